booth2_seq_multiplier: RTL and testbench

BOOTH2_SEQ_MULTIPLIER -- requirements
Module: booth2_seq_multiplier

---
 rtl/booth2_pkg.sv | 32 +++
 rtl/partial_product.sv | 34 +++
 rtl/booth2_seq_multiplier.sv | 124 ++++++++++++
 tb/tb_booth2_seq_multiplier.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/booth2_pkg.sv
// Shared types, widths and the Booth partial-product scaling helper for
// the sequential radix-4 Booth multiplier.
package booth2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MW   = 4;
  localparam int PW   = 8;
  localparam int ACCW = 10;
  localparam int NDIG = 3;
  localparam int XRW  = 7;

  // {n,p}+n completes the ones'-complement negation, so the 111 digit lands on exactly 0.
  function automatic logic [ACCW-1:0] booth_term(input logic [4:0] p, input logic n,
                                                 input logic [1:0] k);
    logic [5:0]      v;
    logic [ACCW-1:0] ext;
    v   = {n, p} + {5'b00000, n};
    ext = {{(ACCW-6){v[5]}}, v};
    case (k)
      2'd0:    booth_term = ext;
      2'd1:    booth_term = {ext[ACCW-3:0], 2'b00};
      2'd2:    booth_term = {ext[ACCW-5:0], 4'b0000};
      default: booth_term = {ACCW{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/partial_product.sv
// Radix-4 Booth recode/select: turns a multiplier triplet into a 5-bit
// ones'-complement partial-product magnitude plus its negate/correction bit.
module partial_product
  import booth2_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    triplet,
  input  logic [MW-1:0] m,
  output logic [4:0]    p,
  output logic          cout
);

  logic [4:0] mag_s;
  logic       unused_clk_rst_s;

  // Purely combinational; the clock/reset ports exist only for drop-in reuse.
  assign unused_clk_rst_s = clk ^ rst;

  always_comb begin
    mag_s = 5'b00000;
    case (triplet)
      3'b000, 3'b111: mag_s = 5'b00000;
      3'b001, 3'b010: mag_s = {1'b0, m};
      3'b011, 3'b100: mag_s = {m, 1'b0};
      3'b101, 3'b110: mag_s = {1'b0, m};
      default:        mag_s = 5'b00000;
    endcase
  end

  assign p    = triplet[2] ? ~mag_s : mag_s;
  assign cout = triplet[2];

endmodule

// File: rtl/booth2_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, 4x4 unsigned -> 8-bit product.
// One Booth digit is accumulated per RUN cycle; three digits cover the zero-extended multiplier.
module booth2_seq_multiplier
  import booth2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] m,
  input  logic [3:0] x,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  state_e          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [XRW-1:0]  xr_q, xr_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [1:0]      k_q, k_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [2:0]      triplet_s;
  logic [4:0]      pp_p_s;
  logic            pp_cout_s;
  logic [ACCW-1:0] sum_s;

  always_comb begin
    triplet_s = 3'b000;
    case (k_q)
      2'd0:    triplet_s = xr_q[2:0];
      2'd1:    triplet_s = xr_q[4:2];
      2'd2:    triplet_s = xr_q[6:4];
      default: triplet_s = 3'b000;
    endcase
  end

  partial_product u_pp (
    .clk     (clk),
    .rst     (rst),
    .triplet (triplet_s),
    .m       (m_q),
    .p       (pp_p_s),
    .cout    (pp_cout_s)
  );

  // Accumulator wraps modulo 2^10; intermediate negatives resolve by the last digit.
  assign sum_s = acc_q + booth_term(pp_p_s, pp_cout_s, k_q);

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    xr_d      = xr_q;
    acc_d     = acc_q;
    k_d       = k_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = m;
          xr_d    = {2'b00, x, 1'b0};
          acc_d   = {ACCW{1'b0}};
          k_d     = 2'd0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sum_s;
        if (k_q == 2'(NDIG - 1)) begin
          k_d       = 2'd0;
          product_d = sum_s[PW-1:0];
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = RUN;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= {MW{1'b0}};
      xr_q      <= {XRW{1'b0}};
      acc_q     <= {ACCW{1'b0}};
      k_q       <= 2'd0;
      product_q <= {PW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      xr_q      <= xr_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth2_seq_multiplier.sv
// Directed + exhaustive bench for booth2_seq_multiplier with a product scoreboard.
module tb_booth2_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] m;
  logic [3:0] x;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int         n_total = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         cyc_cnt = 0;
  int         last_done = -1;
  logic [7:0] exp_q[$];

  booth2_seq_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .m       (m),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from an IDLE cycle and follow it through its done cycle.
  task automatic do_op(input logic [3:0] mm, input logic [3:0] xx, input bit poke,
                       input bit chk_gap);
    int cyc;
    m     = mm;
    x     = xx;
    start = 1'b1;
    exp_q.push_back({4'b0000, mm} * {4'b0000, xx});
    step();
    start = 1'b0;
    m     = 4'hf;
    x     = 4'hf;
    cyc   = 1;
    if (poke) begin
      m     = 4'd3;
      x     = 4'd3;
      start = 1'b1;
    end
    while (done !== 1'b1 && cyc < 8) begin
      check("busy_run", busy, 1);
      step();
      start = 1'b0;
      cyc++;
    end
    check("latency", cyc, 4);
    check("busy_done", busy, 1);
    check("product", product, exp_q.pop_front());
    if (chk_gap && last_done >= 0) check("done_gap", cyc_cnt - last_done, 5);
    last_done = cyc_cnt;
    step();
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic watch_quiet(input logic [7:0] prod_exp);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_done", done, 0);
      check("prod_hold", product, prod_exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    m     = 4'd0;
    x     = 4'd0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    rst = 1'b0;
    step();

    do_op(4'd15, 4'd15, 1'b0, 1'b0);
    do_op(4'd9, 4'd6, 1'b0, 1'b0);
    do_op(4'd7, 4'd7, 1'b0, 1'b0);

    // Start pulsed during RUN must be dropped, not queued.
    do_op(4'd0, 4'd13, 1'b1, 1'b0);
    watch_quiet(8'd0);
    do_op(4'd3, 4'd3, 1'b0, 1'b0);

    // Abort 12*11 in its second RUN cycle.
    m     = 4'd12;
    x     = 4'd11;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    watch_quiet(8'd0);
    do_op(4'd12, 4'd11, 1'b0, 1'b0);

    last_done = -1;
    for (int mi = 0; mi < 16; mi++) begin
      for (int xi = 0; xi < 16; xi++) begin
        do_op(4'(mi), 4'(xi), 1'b0, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
